// File: rtl/lcd_pkg.sv
// LCD command/data word definitions and the power-on init/banner image.
// Shared by the sequenced word buffer and its controller.
package lcd_pkg;

  localparam int LCD_WORD_W   = 9;
  localparam int LCD_RS_BIT   = 8;
  localparam int LCD_INIT_LEN = 40;

  localparam logic [LCD_WORD_W-1:0] LCD_CMD_FUNC_SET = 9'h038;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_DISP_ON  = 9'h00C;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_CLEAR    = 9'h001;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_ENTRY    = 9'h006;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_LINE1    = 9'h080;
  localparam logic [LCD_WORD_W-1:0] LCD_CMD_LINE2    = 9'h0C0;
  localparam logic [LCD_WORD_W-1:0] LCD_DATA_SPACE   = 9'h120;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } lcd_seq_state_t;

  // Character data word: RS set, ASCII code in the low byte.
  function automatic logic [LCD_WORD_W-1:0] lcd_char(
    input logic [7:0] ch
  );
    logic [LCD_WORD_W-1:0] w;
    w = '0;
    w[LCD_RS_BIT] = 1'b1;
    w[7:0] = ch;
    return w;
  endfunction

  localparam logic [LCD_WORD_W-1:0]
    LCD_INIT_IMAGE [LCD_INIT_LEN] = '{
    LCD_CMD_FUNC_SET,
    LCD_CMD_DISP_ON,
    LCD_CMD_CLEAR,
    LCD_CMD_ENTRY,
    LCD_CMD_LINE1,
    LCD_DATA_SPACE,
    lcd_char(8'h48),
    lcd_char(8'h45),
    lcd_char(8'h4C),
    lcd_char(8'h4C),
    lcd_char(8'h4F),
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_CMD_LINE2,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE,
    LCD_DATA_SPACE, LCD_DATA_SPACE
  };

endpackage

// File: rtl/lcd_seq_ctrl.sv
// Streaming sequencer: IDLE/FETCH/SEND FSM with pointer, word count,
// valid/ready handshake, loop and abort handling.
module lcd_seq_ctrl
  import lcd_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop,
  input  logic              abort,
  input  logic              out_ready,
  output lcd_seq_state_t    state,
  output logic [ADDR_W-1:0] ptr,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_inc;
  logic [ADDR_W:0]   len_clamp;
  logic              loop_q;

  assign count_inc = count + CNT_ONE;
  assign len_clamp = (length > DEPTH_L) ? DEPTH_L : length;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      count     <= '0;
      base_q    <= '0;
      len_q     <= '0;
      loop_q    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // Abort wins over start and over a same-cycle handshake.
      if (abort) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (start && length != '0) begin
              base_q <= base_addr;
              len_q  <= len_clamp;
              loop_q <= loop;
              ptr    <= base_addr;
              count  <= '0;
              busy   <= 1'b1;
              state  <= FETCH;
            end
          end
          FETCH: begin
            out_valid <= 1'b1;
            state     <= SEND;
          end
          SEND: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (count_inc == len_q) begin
                if (loop_q) begin
                  ptr   <= base_q;
                  count <= '0;
                  state <= FETCH;
                end else begin
                  ptr   <= ptr + PTR_ONE;
                  count <= count_inc;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= IDLE;
                end
              end else begin
                ptr   <= ptr + PTR_ONE;
                count <= count_inc;
                state <= FETCH;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/lcd_cmd_seq_buffer.sv
// LCD word store with streaming sequencer; LCD_SEQ_INIT_IMAGE_EN
// selects the init/banner image as the reset contents.
module lcd_cmd_seq_buffer
  import lcd_pkg::*;
#(
  parameter int WORD_W = LCD_WORD_W,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WORD_W-1:0] rd_data,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              loop,
  input  logic              abort,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  logic [WORD_W-1:0] rf [DEPTH];
  lcd_seq_state_t    state;
  logic [ADDR_W-1:0] ptr;
  logic              fetch_ld;
  logic [WORD_W-1:0] fetch_word;

  lcd_seq_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .loop      (loop),
    .abort     (abort),
    .out_ready (out_ready),
    .state     (state),
    .ptr       (ptr),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
`ifdef LCD_SEQ_INIT_IMAGE_EN
        rf[i] <= (i < LCD_INIT_LEN)
          ? WORD_W'(LCD_INIT_IMAGE[i % LCD_INIT_LEN])
          : '0;
`else
        rf[i] <= '0;
`endif
      end
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign rd_data = rf[rd_addr];

  // Same-cycle write to the fetched entry is forwarded.
  assign fetch_word = (wr_en && wr_addr == ptr)
    ? wr_data : rf[ptr];
  assign fetch_ld = (state == FETCH) && !abort;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else if (fetch_ld) begin
      out_data <= fetch_word;
    end
  end

endmodule

// File: tb/tb_lcd_cmd_seq_buffer.sv
// Directed bench for lcd_cmd_seq_buffer: streaming, wrap, stall,
// loop, abort, length edge cases and asynchronous reset.
module tb_lcd_cmd_seq_buffer;

  localparam int WORD_W = 9;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              loop;
  logic              abort;
  logic              out_valid;
  logic [WORD_W-1:0] out_data;
  logic              out_ready;
  logic              busy;
  logic              done;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;

`ifdef LCD_SEQ_INIT_IMAGE_EN
  logic [8:0] img_exp [6] = '{9'h038, 9'h00C, 9'h001,
                              9'h006, 9'h080, 9'h120};
`else
  logic [8:0] img_exp [6] = '{default: 9'h000};
`endif

  lcd_cmd_seq_buffer #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .loop      (loop),
    .abort     (abort),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [5:0] a, input logic [8:0] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [5:0] b,
                             input logic [6:0] l,
                             input logic lp);
    base_addr = b;
    length = l;
    loop = lp;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Waits (bounded) for a valid word, samples it, then lets one edge pass.
  task automatic grab_word(output logic [8:0] w, output bit ok);
    int c;
    c = 0;
    ok = 1'b1;
    while (out_valid !== 1'b1 && ok) begin
      step();
      c++;
      if (c > 20) ok = 1'b0;
    end
    w = out_data;
    step();
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {out_valid, busy, done});
    end
    n_chk++;
    if (out_data !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h want 000", out_data);
    end
    for (int a = 0; a < 6; a++) begin
      rd_addr = 6'(a);
      #1;
      n_chk++;
      if (rd_data !== img_exp[a]) begin
        n_fail++;
        $display("FAIL reset_rd[%0d]: got %h want %h",
                 a, rd_data, img_exp[a]);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_basic();
    logic [8:0] exp_w [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    logic [8:0] w;
    bit ok;
    int d0;
    for (int i = 0; i < 5; i++) wr_word(6'(i), exp_w[i]);
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(6'd0, 7'd5, 1'b0);
    n_chk++;
    if ({busy, out_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_fetch: busy,valid got %b want 10",
               {busy, out_valid});
    end
    step();
    n_chk++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_latency: valid got %b want 1", out_valid);
    end
    for (int i = 0; i < 5; i++) begin
      grab_word(w, ok);
      n_chk++;
      if (!ok || w !== exp_w[i]) begin
        n_fail++;
        $display("FAIL basic_word[%0d]: got %h ok=%0d want %h",
                 i, w, ok, exp_w[i]);
      end
    end
    n_chk++;
    if ({done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL basic_done: done,busy got %b want 10",
               {done, busy});
    end
    step();
    n_chk++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      n_fail++;
      $display("FAIL basic_done_once: done=%b pulses=%0d want 0/1",
               done, done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    logic [8:0] exp_w [4] = '{9'h111, 9'h122, 9'h038, 9'h00C};
    logic [8:0] w;
    bit ok;
    wr_word(6'd62, 9'h111);
    wr_word(6'd63, 9'h122);
    out_ready = 1'b1;
    pulse_start(6'd62, 7'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      grab_word(w, ok);
      n_chk++;
      if (!ok || w !== exp_w[i]) begin
        n_fail++;
        $display("FAIL wrap_word[%0d]: got %h ok=%0d want %h",
                 i, w, ok, exp_w[i]);
      end
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_stall_write();
    logic [8:0] exp_w [4] = '{9'h001, 9'h006, 9'h1AA, 9'h006};
    logic [8:0] w;
    bit ok;
    out_ready = 1'b0;
    pulse_start(6'd2, 7'd2, 1'b1);
    step();
    wr_en = 1'b1;
    wr_addr = 6'd2;
    wr_data = 9'h1AA;
    for (int i = 0; i < 5; i++) begin
      step();
      wr_en = 1'b0;
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 9'h001) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h want 1/001",
                 i, out_valid, out_data);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      grab_word(w, ok);
      n_chk++;
      if (!ok || w !== exp_w[i]) begin
        n_fail++;
        $display("FAIL stall_word[%0d]: got %h ok=%0d want %h",
                 i, w, ok, exp_w[i]);
      end
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL stall_abort: valid,busy got %b want 00",
               {out_valid, busy});
    end
  endtask

  task automatic test_loop_abort();
    logic [8:0] exp_w [3] = '{9'h038, 9'h00C, 9'h001};
    logic [8:0] w;
    bit ok;
    int d0;
    int c;
    wr_word(6'd2, 9'h001);
    out_ready = 1'b1;
    d0 = done_cnt;
    pulse_start(6'd0, 7'd3, 1'b1);
    for (int i = 0; i < 9; i++) begin
      grab_word(w, ok);
      n_chk++;
      if (!ok || w !== exp_w[i % 3]) begin
        n_fail++;
        $display("FAIL loop_word[%0d]: got %h ok=%0d want %h",
                 i, w, ok, exp_w[i % 3]);
      end
    end
    out_ready = 1'b0;
    c = 0;
    while (out_valid !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_chk++;
    if ({out_valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL loop_abort: valid,busy,done got %b want 000",
               {out_valid, busy, done});
    end
    step();
    n_chk++;
    if (done_cnt != d0) begin
      n_fail++;
      $display("FAIL loop_no_done: pulses got %0d want 0",
               done_cnt - d0);
    end
  endtask

  task automatic test_len_zero();
    int d0;
    d0 = done_cnt;
    pulse_start(6'd0, 7'd0, 1'b0);
    n_chk++;
    if ({busy, out_valid} !== 2'b00) begin
      n_fail++;
      $display("FAIL len0_idle: busy,valid got %b want 00",
               {busy, out_valid});
    end
    step();
    step();
    n_chk++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL len0_no_done: pulses=%0d busy=%b want 0/0",
               done_cnt - d0, busy);
    end
  endtask

  task automatic test_start_busy();
    logic [8:0] exp_w [3] = '{9'h038, 9'h00C, 9'h001};
    logic [8:0] w;
    bit ok;
    out_ready = 1'b1;
    pulse_start(6'd0, 7'd3, 1'b0);
    grab_word(w, ok);
    n_chk++;
    if (!ok || w !== exp_w[0]) begin
      n_fail++;
      $display("FAIL busy_word[0]: got %h ok=%0d want %h",
               w, ok, exp_w[0]);
    end
    pulse_start(6'd62, 7'd1, 1'b0);
    for (int i = 1; i < 3; i++) begin
      grab_word(w, ok);
      n_chk++;
      if (!ok || w !== exp_w[i]) begin
        n_fail++;
        $display("FAIL busy_word[%0d]: got %h ok=%0d want %h",
                 i, w, ok, exp_w[i]);
      end
    end
    n_chk++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_done: got %b want 1", done);
    end
    step();
  endtask

  task automatic test_clamp();
    logic [8:0] w;
    bit ok;
    int got;
    got = 0;
    out_ready = 1'b1;
    pulse_start(6'd0, 7'd100, 1'b0);
    for (int i = 0; i < 64; i++) begin
      grab_word(w, ok);
      if (ok) got++;
    end
    n_chk++;
    if (got != 64 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL clamp: words=%0d done=%b want 64/1", got, done);
    end
    step();
  endtask

  task automatic test_reset_mid();
    wr_word(6'd0, 9'h0AB);
    out_ready = 1'b0;
    pulse_start(6'd0, 7'd5, 1'b0);
    step();
    #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, busy, done} !== 3'b000 || out_data !== 9'h000) begin
      n_fail++;
      $display("FAIL rst_mid: flags=%b data=%h want 000/000",
               {out_valid, busy, done}, out_data);
    end
    rd_addr = 6'd0;
    #1;
    n_chk++;
    if (rd_data !== img_exp[0]) begin
      n_fail++;
      $display("FAIL rst_mid_rf: got %h want %h", rd_data, img_exp[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    start = 1'b0;
    base_addr = '0;
    length = '0;
    loop = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_stall_write();
    test_loop_abort();
    test_len_zero();
    test_start_busy();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lcd_cmd_seq_buffer.md
Name: lcd_cmd_seq_buffer

Overview:
Parametrised LCD command/data word store with a built-in streaming sequencer. It is the next generation of the LCD controller's word memory and adds generic word width and depth, a valid/ready output stream, programmable base and length, loop mode and abort. Each word is {RS, DB[7:0]} by default (bit WORD_W-1 = RS). It sits between the host/config logic and the LCD timing engine, which consumes the stream.

Parameters:
WORD_W, 9, stored word width; MSB is the RS flag
DEPTH, 64, number of entries; must be a power of 2, at least 8
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
wr_en  in  1  write strobe for the random-access port
wr_addr  in  ADDR_W  write address
wr_data  in  WORD_W  write data
rd_addr  in  ADDR_W  random-access read address
rd_data  out  WORD_W  combinational read, rf[rd_addr]
start  in  1  start request for the sequencer, single-cycle
base_addr  in  ADDR_W  first entry to stream, sampled on start
length  in  ADDR_W+1  number of words to stream, sampled on start
loop  in  1  repeat the sequence until abort, sampled on start
abort  in  1  stop streaming
out_valid  out  1  stream word valid
out_data  out  WORD_W  stream word, registered
out_ready  in  1  consumer accepts the word
busy  out  1  sequencer not IDLE
done  out  1  one-cycle pulse when a non-loop sequence completes

Behaviour:
- Reset (rst=0, async): FSM=IDLE; out_valid=0, out_data=0, busy=0, done=0; ptr and count cleared; array set to the init image (see Optional Feature).
- Write port: rf[wr_addr] <= wr_data on posedge when wr_en=1. Writes are allowed in every FSM state.
- FSM states: IDLE, FETCH, SEND.
- IDLE: if start=1 and length!=0, latch base/len/loop, ptr=base_addr, count=0, and go to FETCH. length > DEPTH is clamped to DEPTH. start with length=0 is ignored and gives no done pulse.
- FETCH (1 cycle): out_data <= rf[ptr]. If wr_en && wr_addr==ptr in the same cycle, forward wr_data. Then go to SEND with out_valid=1.
- SEND: out_valid=1 and out_data is held stable until out_ready=1. On handshake: count++ and ptr = (ptr+1) mod DEPTH, wrapping at DEPTH-1 to 0.
  - If count reaches len and loop=0: go to IDLE, out_valid=0, done=1 for one cycle.
  - If count reaches len and loop=1: ptr=base, count=0, go to FETCH, no done pulse.
  - Otherwise go to FETCH.
- Throughput: at most 1 word per 2 cycles. Latency: start at cycle 0 gives out_valid=1 at cycle 2.
- Writes to the entry currently held in SEND do not change out_data; the new value appears on the next fetch of that entry.
- start while busy=1 is ignored. abort takes priority over start and over a handshake in the same cycle.
- abort=1 in any state: next cycle FSM=IDLE, out_valid=0, no done pulse. A word presented in that cycle is not considered transferred.
- busy=1 in FETCH and SEND, and 0 in IDLE.

Optional Feature:
LCD_SEQ_INIT_IMAGE_EN
- Defined: reset loads entries 0..39 with the standard LCD init and banner image from the package: 038,00C,001,006,080,120,148,145,14C,14C,14F, 120 for entries 11..20, 0C0 at entry 21, 120 for entries 22..39. Entries 40..DEPTH-1 are loaded with 0. Image words are zero-extended or truncated to WORD_W.
- Undefined: reset clears all entries to 0.

Decomposition:
- Package lcd_pkg holds:
  - LCD_WORD_W=9 and LCD_RS_BIT=8;
  - LCD_CMD_FUNC_SET=9'h038, LCD_CMD_DISP_ON=9'h00C, LCD_CMD_CLEAR=9'h001, LCD_CMD_ENTRY=9'h006, LCD_CMD_LINE1=9'h080, LCD_CMD_LINE2=9'h0C0, LCD_DATA_SPACE=9'h120;
  - LCD_INIT_IMAGE as a 40-entry constant array;
  - typedef enum logic [1:0] lcd_seq_state_t {IDLE, FETCH, SEND}.
- One sub-module, lcd_seq_ctrl: the FSM, ptr/count registers and handshake logic. The top level keeps the storage array, forwarding mux and init logic.

Test Plan:
- Reset with LCD_SEQ_INIT_IMAGE_EN defined, rd_addr=0..5 -> rd_data=038,00C,001,006,080,120; out_valid=0, busy=0.
- start with base=0, len=5, loop=0, out_ready=1 -> out_data stream 038,00C,001,006,080 on consecutive handshakes, first valid 2 cycles after start; done pulses once, then busy=0.
- base=62, len=4, DEPTH=64 -> words from entries 62,63,0,1 in order, confirming wrap-around.
- out_ready held 0 for 5 cycles in SEND while wr_en writes 1AA to the current ptr -> out_data unchanged and stable; the next pass in loop mode shows 1AA.
- loop=1, len=3 -> pattern repeats for at least 3 passes with no done pulse; abort mid-SEND -> out_valid=0 next cycle, busy=0, done=0.
- start with len=0 -> FSM stays IDLE, no done; start while busy -> ignored, current sequence unaffected; rst asserted mid-SEND -> all outputs return to reset values immediately.
